// File: rtl/div.sv
// div -- 32-bit iterative restoring divider, signed (DIV) or unsigned (DIVU).
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active-high
//   signed_div_i 1 = signed operands, 0 = unsigned
//   opdata1_i    dividend
//   opdata2_i    divisor
//   start_i      request, held high until ready_o is seen
//   annul_i      cancel the operation in flight (flush / exception)
//   result_o     {remainder[63:32], quotient[31:0]}
//   ready_o      result_o is valid (only in END)
//
// Timing: operands latched on edge E0, 32 restoring steps on E0+1..E0+32,
// result registered and ready_o raised on E0+33. A zero divisor skips the
// iteration and completes on E0+1 with a zero result.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      state, state_d;
  logic [5:0]  cnt;
  logic [31:0] rem;
  // Holds the dividend magnitude; quotient bits shift in at the LSB as the
  // dividend bits shift out at the MSB, so after 32 steps it is the quotient.
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic        neg_q, neg_r;

  logic        accept;
  logic        last;
  logic [32:0] trial;
  logic [31:0] q_fix, r_fix;

  assign accept = (state == FREE) && start_i && !annul_i;
  assign last   = (cnt == 6'd32);
  assign trial  = {rem, dvd[31]} - {1'b0, dvs};
  assign q_fix  = neg_q ? -dvd : dvd;
  assign r_fix  = neg_r ? -rem : rem;

  always_comb begin
    state_d = state;
    case (state)
      FREE:    if (accept) state_d = (opdata2_i == 32'd0) ? BYZERO : ON;
      BYZERO:  state_d = annul_i ? FREE : END;
      ON:      if (annul_i) state_d = FREE;
               else if (last) state_d = END;
      END:     if (annul_i || !start_i) state_d = FREE;
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FREE;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      rem   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      rem   <= '0;
      dvd   <= (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
      dvs   <= (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
      neg_q <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
      neg_r <= signed_div_i && opdata1_i[31];
    end else if (state == ON && !annul_i && !last) begin
      // Non-negative trial means the divisor fits: keep the difference.
      // When negative, {rem, msb} < divisor so it still fits in 32 bits.
      if (!trial[32]) rem <= trial[31:0];
      else            rem <= {rem[30:0], dvd[31]};
      dvd <= {dvd[30:0], ~trial[32]};
      cnt <= cnt + 6'd1;
    end
  end

  // Outputs are zero everywhere except END; the result is captured on
  // entry to END and held there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_o  <= 1'b0;
      result_o <= '0;
    end else begin
      ready_o <= (state_d == END);
      if (state_d != END)  result_o <= '0;
      else if (state == ON) result_o <= {r_fix, q_fix};
      else if (state == BYZERO) result_o <= '0;
    end
  end

endmodule

// File: tb/tb_div.sv
// tb_div -- directed self-checking bench for div.
module tb_div;
  logic        clk, rst;
  logic        signed_div_i, start_i, annul_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;

  int nvec = 0;
  int nerr = 0;

  div dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs for E0 are already applied; the next posedge is E0. Counts edges
  // until ready_o, scrambling operands after E0 to show they are latched.
  task automatic wait_res(input string tag, input logic [63:0] exp, input int lat);
    int n;
    n = 0;
    @(posedge clk);
    @(negedge clk);
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~signed_div_i;
    while (!ready_o && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " result"}, result_o, exp);
    @(posedge clk); @(negedge clk);
    chk({tag, " hold"}, {63'd0, ready_o} ^ result_o, 64'd1 ^ exp);
  endtask

  task automatic release_chk(input string tag);
    start_i = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({tag, " free"}, {63'd0, ready_o} | result_o, 64'd0);
  endtask

  task automatic do_op(input string tag, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input int lat);
    @(negedge clk);
    signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1; annul_i = 1'b0;
    wait_res(tag, exp, lat);
    release_chk(tag);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    #1;
    chk("reset ready", {63'd0, ready_o}, 64'd0);
    chk("reset result", result_o, 64'd0);
    #20;
    @(negedge clk); rst = 1'b0;

    do_op("u100/7",  1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, 33);
    do_op("s-7/2",   1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33);
    do_op("s7/-2",   1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
    do_op("u0div",   1'b0, 32'd55,       32'd0,        64'h0, 1);
    do_op("s0div",   1'b1, 32'hFFFFFFF0, 32'd0,        64'h0, 1);
    do_op("smin/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
    do_op("umin/-1", 1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 33);

    // annul seen at E0+10, then restart on the very first FREE edge
    begin
      int rdy_seen;
      rdy_seen = 0;
      @(negedge clk);
      signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1;
      @(posedge clk);
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        if (ready_o) rdy_seen++;
        if (i == 10) annul_i = 1'b1;
        @(posedge clk);
      end
      @(negedge clk);
      chk("annul ready", {63'd0, ready_o} | result_o | 64'(rdy_seen), 64'd0);
      annul_i = 1'b0; opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'd1; signed_div_i = 1'b0;
      wait_res("after annul", 64'h00000000_FFFFFFFF, 33);
      release_chk("after annul");
    end

    // start and annul together in FREE must not be accepted
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    start_i = 1'b1; annul_i = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3;
    wait_res("blocked", 64'h00000000_00000003, 33);
    release_chk("blocked");

    // annul in END
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd20; opdata2_i = 32'd6; start_i = 1'b1;
    wait_res("end annul", 64'h00000002_00000003, 33);
    annul_i = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("end annul free", {63'd0, ready_o} | result_o, 64'd0);
    annul_i = 1'b0; start_i = 1'b0;

    // async reset while in END, between edges
    @(negedge clk);
    opdata1_i = 32'd21; opdata2_i = 32'd4; signed_div_i = 1'b0; start_i = 1'b1;
    wait_res("end rst", 64'h00000001_00000005, 33);
    #1 rst = 1'b1;
    #1;
    chk("end rst async", {63'd0, ready_o} | result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk); rst = 1'b0;

    // async reset at E0+20, then fresh 9/3
    @(negedge clk);
    opdata1_i = 32'd1000; opdata2_i = 32'd10; signed_div_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid rst async", {63'd0, ready_o} | result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk); rst = 1'b0;
    do_op("u9/3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
